// File: rtl/cr_fifo_wrap2_pkg.sv
// Shared types and helpers for the cr_fifo_wrap2 FIFO slice.
// Provides the sticky error struct, pointer wrap helper and count-width helper.
package cr_fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int unsigned cnt_bits(input int unsigned entries);
        return $clog2(entries + 1);
    endfunction

    // Explicit wrap so depths that are not a power of two behave correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned entries);
        return (ptr == entries - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/cr_fifo_wrap2_if.sv
// Write/read handshake and status bundle between a cr_* stage and cr_fifo_wrap2.
// slave = FIFO side, master = producer/consumer side.
interface cr_fifo_wrap2_if #(
    parameter int N_DATA_BITS = 64,
    parameter int N_CNT_BITS  = 4
);
    logic [N_DATA_BITS-1:0] wdata;
    logic                   wen;
    logic                   full;
    logic                   afull;
    logic [N_DATA_BITS-1:0] rdata;
    logic                   rvalid;
    logic                   ren;
    logic                   empty;
    logic                   aempty;
    logic [N_CNT_BITS-1:0]  used_slots;

    modport master (
        output wdata, wen, ren,
        input  full, afull, rdata, rvalid, empty, aempty, used_slots
    );

    modport slave (
        input  wdata, wen, ren,
        output full, afull, rdata, rvalid, empty, aempty, used_slots
    );
endinterface

// File: rtl/cr_fifo_wrap2_ram.sv
// Register-array storage for cr_fifo_wrap2: synchronous write, asynchronous read.
// DATA_RESET=1 clears every entry on reset; DATA_RESET=0 leaves storage unreset.
module cr_fifo_wrap2_ram #(
    parameter int N_DATA_BITS = 64,
    parameter int N_ENTRIES   = 8,
    parameter int DATA_RESET  = 1,
    parameter int PTR_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [PTR_W-1:0]       waddr,
    input  logic [N_DATA_BITS-1:0] wdata,
    input  logic [PTR_W-1:0]       raddr,
    output logic [N_DATA_BITS-1:0] rdata
);
    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

    generate
        if (DATA_RESET != 0) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                        mem[PTR_W'(i)] <= '0;
                    end
                end else if (we) begin
                    mem[waddr] <= wdata;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem[raddr];
endmodule

// File: rtl/cr_fifo_wrap2.sv
// Single-clock FWFT FIFO with programmable almost-full/empty, flush and sticky errors.
// Optional peak-occupancy output enabled by defining CR_FIFO_WRAP2_WATERMARK_EN.
module cr_fifo_wrap2
    import cr_fifo_pkg::*;
#(
    parameter int N_DATA_BITS = 64,
    parameter int N_ENTRIES   = 8,
    parameter int DATA_RESET  = 1,
    parameter int N_CNT_BITS  = cnt_bits(N_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cr_fifo_wrap2_if.slave        bus,
    input  logic                  clear,
    input  logic [N_CNT_BITS-1:0] cfg_afull_lvl,
    input  logic [N_CNT_BITS-1:0] cfg_aempty_lvl,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
`ifdef CR_FIFO_WRAP2_WATERMARK_EN
    ,
    output logic [N_CNT_BITS-1:0] max_used
`endif
);
    localparam int PTR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    generate
        if (N_ENTRIES < 2) begin : g_bad_depth
            $error("cr_fifo_wrap2: N_ENTRIES must be >= 2");
        end
    endgenerate

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [N_CNT_BITS-1:0] used_q, next_used;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  push, pop;
    fifo_err_t             err_q, err_d;

    assign push = bus.wen & ~full_q;
    assign pop  = bus.ren & ~empty_q;

    always_comb begin
        next_used = used_q;
        if (clear) begin
            next_used = '0;
        end else if (push && !pop) begin
            next_used = used_q + N_CNT_BITS'(1);
        end else if (pop && !push) begin
            next_used = used_q - N_CNT_BITS'(1);
        end
    end

    // Error detection ignores clear; a same-cycle new error beats err_clr.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end
        if (bus.wen && full_q) begin
            err_d.overflow = 1'b1;
        end
        if (bus.ren && empty_q) begin
            err_d.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            used_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            err_q    <= '0;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), N_ENTRIES));
                end
                if (pop) begin
                    rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), N_ENTRIES));
                end
            end
            used_q   <= next_used;
            full_q   <= (next_used == N_CNT_BITS'(N_ENTRIES));
            empty_q  <= (next_used == '0);
            afull_q  <= (next_used >= cfg_afull_lvl);
            aempty_q <= (next_used <= cfg_aempty_lvl);
            err_q    <= err_d;
        end
    end

`ifdef CR_FIFO_WRAP2_WATERMARK_EN
    logic [N_CNT_BITS-1:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (err_clr) begin
            max_q <= next_used;
        end else if (next_used > max_q) begin
            max_q <= next_used;
        end
    end

    assign max_used = max_q;
`endif

    cr_fifo_wrap2_ram #(
        .N_DATA_BITS (N_DATA_BITS),
        .N_ENTRIES   (N_ENTRIES),
        .DATA_RESET  (DATA_RESET),
        .PTR_W       (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push & ~clear),
        .waddr (wr_ptr),
        .wdata (bus.wdata),
        .raddr (rd_ptr),
        .rdata (bus.rdata)
    );

    assign bus.full       = full_q;
    assign bus.afull      = afull_q;
    assign bus.empty      = empty_q;
    assign bus.aempty     = aempty_q;
    assign bus.rvalid     = ~empty_q;
    assign bus.used_slots = used_q;
    assign overflow       = err_q.overflow;
    assign underflow      = err_q.underflow;
endmodule

// File: tb/tb_cr_fifo_wrap2.sv
// Directed self-checking bench for cr_fifo_wrap2 (16-bit data, 6 entries, afull=5, aempty=1).
// Watermark checks compile in when CR_FIFO_WRAP2_WATERMARK_EN is defined.
module tb_cr_fifo_wrap2;
    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [2:0] cfg_afull_lvl;
    logic [2:0] cfg_aempty_lvl;
    logic       overflow;
    logic       underflow;
    logic       err_clr;
`ifdef CR_FIFO_WRAP2_WATERMARK_EN
    logic [2:0] max_used;
`endif
    int errors = 0;
    int checks = 0;

    cr_fifo_wrap2_if #(.N_DATA_BITS(16), .N_CNT_BITS(3)) bus ();

    cr_fifo_wrap2 #(
        .N_DATA_BITS (16),
        .N_ENTRIES   (6),
        .DATA_RESET  (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .clear          (clear),
        .cfg_afull_lvl  (cfg_afull_lvl),
        .cfg_aempty_lvl (cfg_aempty_lvl),
        .overflow       (overflow),
        .underflow      (underflow),
        .err_clr        (err_clr)
`ifdef CR_FIFO_WRAP2_WATERMARK_EN
        ,
        .max_used       (max_used)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; err_clr = 1'b0;
        bus.wen = 1'b0; bus.ren = 1'b0; bus.wdata = '0;
        cfg_afull_lvl = 3'd5; cfg_aempty_lvl = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", bus.afull); end
        checks++; if (bus.aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b expected 1", bus.aempty); end
        checks++; if (bus.used_slots !== 3'd0) begin errors++; $display("FAIL reset_used: got %0d expected 0", bus.used_slots); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", overflow, underflow); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", bus.rdata); end
`ifdef CR_FIFO_WRAP2_WATERMARK_EN
        checks++; if (max_used !== 3'd0) begin errors++; $display("FAIL reset_max_used: got %0d expected 0", max_used); end
`endif
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fill;
        for (int k = 1; k <= 6; k++) begin
            bus.wdata = 16'hA000 + 16'(k);
            bus.wen   = 1'b1;
            tick;
            checks++; if (bus.used_slots !== 3'(k)) begin errors++; $display("FAIL fill_used[%0d]: got %0d expected %0d", k, bus.used_slots, k); end
            checks++; if (bus.afull !== (k >= 5)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", k, bus.afull, (k >= 5)); end
            checks++; if (bus.full !== (k == 6)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", k, bus.full, (k == 6)); end
            checks++; if (bus.rdata !== 16'hA001) begin errors++; $display("FAIL fill_head[%0d]: got %h expected a001", k, bus.rdata); end
        end
        bus.wdata = 16'hA007;
        tick;
        bus.wen = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
        checks++; if (bus.used_slots !== 3'd6) begin errors++; $display("FAIL fill_used_after_ovf: got %0d expected 6", bus.used_slots); end
        checks++; if (bus.rdata !== 16'hA001) begin errors++; $display("FAIL fill_head_after_ovf: got %h expected a001", bus.rdata); end
    endtask

    task automatic test_drain;
        bus.ren = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.rdata !== 16'hA001 + 16'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, bus.rdata, 16'hA001 + 16'(i)); end
            tick;
        end
        checks++; if (bus.empty !== 1'b1 || bus.aempty !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++; $display("FAIL drain_flags: got empty=%b aempty=%b rvalid=%b expected 1 1 0", bus.empty, bus.aempty, bus.rvalid);
        end
        tick;
        bus.ren = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow: got %b expected 1", underflow); end
        checks++; if (bus.used_slots !== 3'd0) begin errors++; $display("FAIL drain_used: got %0d expected 0", bus.used_slots); end
    endtask

    task automatic test_fwft;
        bus.wdata = 16'hBEEF; bus.wen = 1'b1;
        tick;
        bus.wen = 1'b0;
        checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL fwft_rvalid: got %b expected 1", bus.rvalid); end
        checks++; if (bus.rdata !== 16'hBEEF) begin errors++; $display("FAIL fwft_rdata: got %h expected beef", bus.rdata); end
        checks++; if (bus.aempty !== 1'b1 || bus.used_slots !== 3'd1) begin
            errors++; $display("FAIL fwft_level: got aempty=%b used=%0d expected 1 1", bus.aempty, bus.used_slots);
        end
        bus.ren = 1'b1;
        tick;
        bus.ren = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_back_to_back;
        bus.wen = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.wdata = 16'hC000 + 16'(k);
            tick;
        end
        for (int i = 0; i < 20; i++) begin
            bus.wdata = 16'hC003 + 16'(i);
            bus.ren   = 1'b1;
            checks++; if (bus.rdata !== 16'hC000 + 16'(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.rdata, 16'hC000 + 16'(i)); end
            tick;
            checks++; if (bus.used_slots !== 3'd3) begin errors++; $display("FAIL b2b_used[%0d]: got %0d expected 3", i, bus.used_slots); end
            checks++; if ({bus.full, bus.empty, bus.afull, bus.aempty} !== 4'b0000) begin
                errors++; $display("FAIL b2b_flags[%0d]: got %b expected 0000", i, {bus.full, bus.empty, bus.afull, bus.aempty});
            end
        end
        bus.wen = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++; if (bus.rdata !== 16'hC014 + 16'(j)) begin errors++; $display("FAIL b2b_tail[%0d]: got %h expected %h", j, bus.rdata, 16'hC014 + 16'(j)); end
            tick;
        end
        bus.ren = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_empty_write;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL errclr: got %b%b expected 00", overflow, underflow); end
        bus.wdata = 16'hD00D; bus.wen = 1'b1; bus.ren = 1'b1;
        tick;
        bus.wen = 1'b0; bus.ren = 1'b0;
        checks++; if (bus.used_slots !== 3'd1 || bus.rdata !== 16'hD00D) begin
            errors++; $display("FAIL empty_write_data: got used=%0d rdata=%h expected 1 d00d", bus.used_slots, bus.rdata);
        end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_write_underflow: got %b expected 1", underflow); end
        err_clr = 1'b1;
        tick;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL errclr2: got %b expected 0", underflow); end
        err_clr = 1'b0; bus.ren = 1'b1;
        tick;
        err_clr = 1'b1;
        tick;
        bus.ren = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", underflow); end
        tick;
        err_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL errclr3: got %b expected 0", underflow); end
    endtask

    task automatic test_clear;
        bus.ren = 1'b1;
        tick;
        bus.ren = 1'b0;
        bus.wen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.wdata = 16'hE000 + 16'(k);
            tick;
        end
        checks++; if (bus.used_slots !== 3'd4) begin errors++; $display("FAIL clear_prefill: got %0d expected 4", bus.used_slots); end
        clear = 1'b1; bus.wdata = 16'hEEEE;
        tick;
        clear = 1'b0; bus.wen = 1'b0;
        checks++; if (bus.used_slots !== 3'd0 || bus.empty !== 1'b1 || bus.afull !== 1'b0 || bus.full !== 1'b0 || bus.aempty !== 1'b1) begin
            errors++; $display("FAIL clear_state: got used=%0d empty=%b afull=%b full=%b aempty=%b expected 0 1 0 0 1",
                               bus.used_slots, bus.empty, bus.afull, bus.full, bus.aempty);
        end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clear_sticky: got %b expected 1", underflow); end
        tick;
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL clear_discard: got rvalid=%b expected 0", bus.rvalid); end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL clear_errclr: got %b%b expected 00", overflow, underflow); end
        bus.wdata = 16'hF00F; bus.wen = 1'b1;
        tick;
        bus.wen = 1'b0;
        checks++; if (bus.rdata !== 16'hF00F) begin errors++; $display("FAIL clear_rewrite: got %h expected f00f", bus.rdata); end
        cfg_aempty_lvl = 3'd0;
        tick;
        checks++; if (bus.aempty !== 1'b0) begin errors++; $display("FAIL cfg_aempty0: got %b expected 0", bus.aempty); end
        cfg_afull_lvl = 3'd0;
        tick;
        checks++; if (bus.afull !== 1'b1) begin errors++; $display("FAIL cfg_afull0: got %b expected 1", bus.afull); end
        cfg_afull_lvl = 3'd5; cfg_aempty_lvl = 3'd1;
        tick;
        checks++; if (bus.afull !== 1'b0 || bus.aempty !== 1'b1) begin
            errors++; $display("FAIL cfg_restore: got afull=%b aempty=%b expected 0 1", bus.afull, bus.aempty);
        end
        bus.ren = 1'b1;
        tick;
        bus.ren = 1'b0;
    endtask

    task automatic test_midreset;
        bus.wen = 1'b1;
        bus.wdata = 16'h1101;
        tick;
        bus.wdata = 16'h1102;
        tick;
        bus.wdata = 16'h1103;
        #2;
        rst_n = 1'b0;
        bus.wen = 1'b0;
        #1;
        checks++; if (bus.used_slots !== 3'd0 || bus.empty !== 1'b1 || bus.rvalid !== 1'b0 || bus.full !== 1'b0) begin
            errors++; $display("FAIL midrst_state: got used=%0d empty=%b rvalid=%b full=%b expected 0 1 0 0",
                               bus.used_slots, bus.empty, bus.rvalid, bus.full);
        end
        checks++; if (bus.afull !== 1'b0 || bus.aempty !== 1'b1 || bus.rdata !== 16'h0000) begin
            errors++; $display("FAIL midrst_flags: got afull=%b aempty=%b rdata=%h expected 0 1 0000", bus.afull, bus.aempty, bus.rdata);
        end
`ifdef CR_FIFO_WRAP2_WATERMARK_EN
        checks++; if (max_used !== 3'd0) begin errors++; $display("FAIL midrst_max_used: got %0d expected 0", max_used); end
`endif
        tick;
        rst_n = 1'b1;
        tick;
        bus.wen = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.wdata = 16'h2200 + 16'(k);
            tick;
        end
        bus.wen = 1'b0;
        checks++; if (bus.full !== 1'b1 || bus.used_slots !== 3'd6) begin
            errors++; $display("FAIL refill: got full=%b used=%0d expected 1 6", bus.full, bus.used_slots);
        end
        checks++; if (bus.rdata !== 16'h2200) begin errors++; $display("FAIL refill_head: got %h expected 2200", bus.rdata); end
`ifdef CR_FIFO_WRAP2_WATERMARK_EN
        checks++; if (max_used !== 3'd6) begin errors++; $display("FAIL refill_max_used: got %0d expected 6", max_used); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_fwft;
        test_back_to_back;
        test_empty_write;
        test_clear;
        test_midreset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
